// File: rtl/reg_pipeline.sv
// reg_pipeline: elastic chain of DEPTH valid-tagged register stages.
// Words advance toward the output whenever the stage ahead is empty or is
// itself moving on, so bubbles collapse under backpressure.
//
// Handshake: a word crosses a port only in a cycle where valid && ready are
// both high at the rising edge. The in_valid/in_data pair never depends on
// in_ready. in_ready depends combinationally on out_ready through the
// ready chain. out_valid/out_data come straight from the last stage register
// and hold steady while out_valid && !out_ready.
module reg_pipeline #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              OCC_W       = $clog2(DEPTH+1)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0]            ld;
  logic [OCC_W-1:0]            occ_c;
  logic                        push;

  // Ready chain: a stage advances if the one ahead is empty or advancing.
  always_comb begin
    adv            = '0;
    adv[DEPTH-1]   = out_ready;
    for (int i = DEPTH-2; i >= 0; i--) begin
      adv[i] = !v_q[i+1] || adv[i+1];
    end
    ld = ~v_q | adv;
  end

  assign in_ready = ld[0] && !flush && !clear;
  assign push     = in_valid && in_ready;

  // Next-state for valid bits and data; data only moves with a valid word.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (ld[0]) begin
      v_d[0] = push;
      if (push) begin
        d_d[0] = in_data;
      end
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (ld[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) begin
          d_d[i] = d_q[i-1];
        end
      end
    end
  end

  // Stage registers: clear wins over flush; flush keeps the data words.
  always_ff @(posedge clock) begin
    if (clear) begin
      v_q <= '0;
      d_q <= {DEPTH{RESET_VALUE}};
    end else if (flush) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  // Occupancy is the number of valid stages.
  always_comb begin
    occ_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_c = occ_c + OCC_W'(v_q[i]);
    end
  end

  assign occupancy = occ_c;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

endmodule

// File: tb/tb_reg_pipeline.sv
// Bench for reg_pipeline: DEPTH=4 instance against a positional queue model,
// plus a DEPTH=1 instance with directed checks.
module tb_reg_pipeline;

  localparam int         W   = 8;
  localparam int         D   = 4;
  localparam logic [W-1:0] RV  = 8'hC3;
  localparam logic [W-1:0] RV1 = 8'h3C;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         clr, fl, iv, ir, ov, ordy;
  logic [W-1:0] id, od;
  logic [2:0]   occ;

  logic         clr1, fl1, iv1, ir1, ov1, ordy1;
  logic [W-1:0] id1, od1;
  logic [0:0]   occ1;

  reg_pipeline #(.WIDTH(W), .DEPTH(D), .RESET_VALUE(RV)) u_dut (
    .clock(clk), .clear(clr), .flush(fl),
    .in_valid(iv), .in_ready(ir), .in_data(id),
    .out_valid(ov), .out_ready(ordy), .out_data(od),
    .occupancy(occ)
  );

  reg_pipeline #(.WIDTH(W), .DEPTH(1), .RESET_VALUE(RV1)) u_dut1 (
    .clock(clk), .clear(clr1), .flush(fl1),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1),
    .occupancy(occ1)
  );

  // ---------------- scoreboard state ----------------
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q[$];   // words held, oldest first
  int           pos_q[$];   // stage index of each held word
  logic [W-1:0] last_out;   // word last seen in the output stage
  logic [W-1:0] out_log[$]; // words delivered through the output port
  logic         last_acc;
  int           acc_cnt;
  int           first_valid;
  int           cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver + model, one clock per call ----------------
  task automatic step(input logic v_in, input logic [W-1:0] d_in, input logic rdy,
                      input logic f, input logic c);
    int   newpos[$];
    int   a;
    int   np;
    logic m_ready;
    @(negedge clk);
    iv = v_in; id = d_in; ordy = rdy; fl = f; clr = c;
    #1;
    // Each word moves one stage unless the slot ahead stays occupied;
    // the oldest word leaves when it sits in the last stage and rdy is high.
    newpos.delete();
    a = rdy ? D + 1 : D;
    foreach (pos_q[k]) begin
      np = (pos_q[k] + 1 < a) ? pos_q[k] + 1 : pos_q[k];
      newpos.push_back(np);
      a = np;
    end
    m_ready = !f && !c && (newpos.size() == 0 || newpos[newpos.size()-1] > 0);
    check("in_ready", 32'(ir), 32'(m_ready));
    check("out_valid", 32'(ov), 32'(pos_q.size() > 0 && pos_q[0] == D-1));
    check("out_data", 32'(od), 32'(last_out));
    check("occupancy", 32'(occ), 32'(pos_q.size()));
    if (first_valid < 0 && ov) first_valid = cyc;
    last_acc = v_in && ir;
    if (last_acc) acc_cnt++;
    if (ov && rdy && !f && !c) out_log.push_back(od);
    if (c) begin
      exp_q.delete(); pos_q.delete(); last_out = RV;
    end else if (f) begin
      exp_q.delete(); pos_q.delete();
    end else begin
      pos_q = newpos;
      if (pos_q.size() > 0 && pos_q[0] == D) begin
        void'(pos_q.pop_front());
        void'(exp_q.pop_front());
      end
      if (v_in && m_ready) begin
        exp_q.push_back(d_in);
        pos_q.push_back(0);
      end
      if (pos_q.size() > 0 && pos_q[0] == D-1) last_out = exp_q[0];
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0, 1'b0);
  endtask

  task automatic restart_log();
    out_log.delete();
    acc_cnt = 0;
    cyc = 0;
    first_valid = -1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int idx;
    clr = 1'b1; fl = 1'b0; iv = 1'b0; ordy = 1'b0; id = '0;
    clr1 = 1'b1; fl1 = 1'b0; iv1 = 1'b0; ordy1 = 1'b0; id1 = '0;
    last_out = RV;
    restart_log();
    repeat (2) @(posedge clk);

    // Reset: clear held with in_valid high, then release
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
    @(negedge clk); iv = 1'b0; clr = 1'b0; #1;
    check("reset_out_valid", 32'(ov), 32'd0);
    check("reset_out_data", 32'(od), 32'(RV));
    check("reset_occupancy", 32'(occ), 32'd0);
    check("reset_in_ready", 32'(ir), 32'd1);

    // Streaming 0x01..0x10 with out_ready high
    restart_log();
    for (int i = 1; i <= 16; i++) step(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
    idle(5, 1'b1);
    check("stream_latency", 32'(first_valid), 32'd4);
    check("stream_count", 32'(out_log.size()), 32'd16);
    for (int i = 0; i < 16 && i < out_log.size(); i++)
      check("stream_word", 32'(out_log[i]), 32'(i + 1));

    // Backpressure: offer 0xA0..0xA5 with out_ready low
    restart_log();
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, W'(8'hA0 + idx), 1'b0, 1'b0, 1'b0);
      if (last_acc) idx++;
    end
    check("bp_accepted", 32'(acc_cnt), 32'd4);
    @(negedge clk); ordy = 1'b0; iv = 1'b1; #1;
    check("bp_occupancy", 32'(occ), 32'd4);
    check("bp_in_ready", 32'(ir), 32'd0);
    check("bp_out_data", 32'(od), 32'hA0);
    for (int i = 0; i < 20 && idx < 6; i++) begin
      step(1'b1, W'(8'hA0 + idx), 1'b1, 1'b0, 1'b0);
      if (last_acc) idx++;
    end
    idle(6, 1'b1);
    check("bp_count", 32'(out_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < out_log.size(); i++)
      check("bp_word", 32'(out_log[i]), 32'(8'hA0 + i));

    // Bubble collapse under backpressure
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    @(negedge clk); iv = 1'b0; #1;
    check("bubble_occupancy", 32'(occ), 32'd2);
    check("bubble_out_data", 32'(od), 32'h11);
    check("bubble_in_ready", 32'(ir), 32'd1);
    idle(4, 1'b1);

    // Flush with three words in flight
    for (int i = 0; i < 3; i++) step(1'b1, W'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    @(negedge clk); iv = 1'b0; #1;
    check("flush_occupancy", 32'(occ), 32'd0);
    check("flush_out_valid", 32'(ov), 32'd0);
    check("flush_out_data", 32'(od), 32'h22);
    restart_log();
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    idle(6, 1'b1);
    check("flush_latency", 32'(first_valid), 32'd4);
    check("flush_word", 32'(out_log.size() > 0 ? out_log[0] : 8'h00), 32'h77);

    // Randomized traffic with occasional flush and clear
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 99) == 0));
    end
    idle(6, 1'b1);

    // DEPTH = 1 instance
    @(negedge clk); clr1 = 1'b0; iv1 = 1'b1; id1 = 8'h41; ordy1 = 1'b1; #1;
    check("d1_in_ready_empty", 32'(ir1), 32'd1);
    check("d1_out_data_reset", 32'(od1), 32'(RV1));
    @(negedge clk); iv1 = 1'b1; id1 = 8'h42; ordy1 = 1'b1; #1;
    check("d1_out_valid", 32'(ov1), 32'd1);
    check("d1_out_data", 32'(od1), 32'h41);
    check("d1_in_ready_full_pop", 32'(ir1), 32'd1);
    @(negedge clk); iv1 = 1'b1; id1 = 8'h43; ordy1 = 1'b0; #1;
    check("d1_occupancy_swap", 32'(occ1), 32'd1);
    check("d1_out_data_swap", 32'(od1), 32'h42);
    check("d1_in_ready_full_stall", 32'(ir1), 32'd0);
    @(negedge clk); clr1 = 1'b1; iv1 = 1'b1; ordy1 = 1'b1; #1;
    check("d1_in_ready_clear", 32'(ir1), 32'd0);
    @(negedge clk); clr1 = 1'b0; iv1 = 1'b0; #1;
    check("d1_clear_out_valid", 32'(ov1), 32'd0);
    check("d1_clear_out_data", 32'(od1), 32'(RV1));
    check("d1_clear_occupancy", 32'(occ1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_pipeline.md
# reg_pipeline

Parametrised elastic register pipeline: a chain of DEPTH clocked register stages, each WIDTH bits wide with its own valid bit, moved by a valid/ready handshake on both ends. It extends the single clearable D flip-flop to multi-bit, multi-stage storage with backpressure, bubble collapsing and flush. It sits between producer and consumer datapath blocks that need fixed registered latency but may stall independently.

## Interface

- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- RESET_VALUE, 0, value loaded into every data register on clear (WIDTH bits)
- OCC_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

- clock  input  1  single clock; all state changes on posedge clock
- clear  input  1  reset, synchronous, active-high
- flush  input  1  synchronous discard of all held entries
- in_valid  input  1  producer presents in_data
- in_ready  output  1  pipeline accepts in_data this cycle
- in_data  input  WIDTH  input word
- out_valid  output  1  stage DEPTH-1 holds a valid word
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  WIDTH  word in stage DEPTH-1
- occupancy  output  OCC_W  number of valid stages, 0..DEPTH

## Operation

- State per stage i (0 = input side, DEPTH-1 = output side): v[i], d[i].
- Stage advance condition: adv[DEPTH-1] = out_ready; adv[i] = !v[i+1] || adv[i+1] for i < DEPTH-1.
- Stage load condition: ld[i] = !v[i] || adv[i] (stage empty or its content moves on).
- in_ready = ld[0] && !flush && !clear; combinational from valid bits, out_ready, flush, clear.
- Input handshake: in_valid && in_ready. Output handshake: out_valid && out_ready.
- On posedge, normal mode, each stage i with ld[i] true:
  - i = 0: v[0] <= in_valid && in_ready; d[0] <= in_data when the input handshake occurs.
  - i > 0: v[i] <= v[i-1]; d[i] <= d[i-1] when v[i-1].
  - Stages with ld[i] false hold v[i], d[i].
- Data registers load only when a valid word moves in; otherwise they hold (no change on bubbles).
- Bubble collapse: an empty stage downstream of a stalled stage still fills; words pack toward the output under backpressure.
- out_valid = v[DEPTH-1]; out_data = d[DEPTH-1]; out_data stays stable while out_valid && !out_ready.
- occupancy = popcount of v[0..DEPTH-1], combinational.
- Priority per cycle: clear > flush > normal.
  - clear: all v <= 0, all d <= RESET_VALUE.
  - flush: all v <= 0, d unchanged; no input handshake (in_ready = 0); an output handshake presented in a flush cycle is not counted as delivered.
- Order preserving: words leave in acceptance order; no drop, no duplication outside flush/clear.
- DEPTH = 1: single stage, in_ready = !v[0] || out_ready.

## Timing

- Reset values (cycle after clear high): out_valid = 0, out_data = RESET_VALUE, occupancy = 0; in_ready = 0 while clear high, = 1 the cycle after clear is released (pipeline empty).
- Latency: word accepted at edge t is on out_data with out_valid = 1 after edge t+DEPTH-1 (DEPTH cycles input handshake to output visible), when no stall is in its path.
- Throughput: one word per cycle with out_ready held high, sustained indefinitely.
- Full: occupancy = DEPTH and out_ready = 0 → in_ready = 0 same cycle. Full with out_ready = 1 → in_ready = 1 (simultaneous push and pop, occupancy unchanged).
- Empty: out_valid = 0; out_ready ignored.
- clear or flush mid-stream: takes effect at that edge; words in flight are lost; next accepted word sees full DEPTH latency.
- No combinational path from in_valid/in_data to out_*; out_ready → in_ready is combinational (ready chain).

## Test plan

- Reset: hold clear 2 cycles with in_valid = 1 → in_ready = 0, then out_valid = 0, out_data = RESET_VALUE, occupancy = 0; in_ready = 1 first cycle after release.
- Streaming (WIDTH=8, DEPTH=4): push 0x01..0x10 back-to-back, out_ready = 1 → 0x01 visible after 4 cycles, then one word per cycle in order, occupancy steady at 4, no gaps.
- Backpressure: out_ready = 0, offer 0xA0..0xA5 → exactly 4 accepted, in_ready = 0 from then on, occupancy = 4, out_data = 0xA0 stable; raise out_ready → 0xA0..0xA3 drain in order, then 0xA4, 0xA5 accepted.
- Bubble collapse: push 0x11, idle 2 cycles, push 0x22, out_ready = 0 → both pack to stages 3 and 2, occupancy = 2, in_ready stays 1.
- Flush: occupancy = 3, assert flush one cycle with in_valid = 1 → in_ready = 0 that cycle, occupancy = 0 next cycle, out_data unchanged, out_valid = 0; subsequent word has 4-cycle latency.
- Clear mid-operation with DEPTH = 1 and full pipeline, out_ready = 1 → next cycle out_valid = 0, out_data = RESET_VALUE; simultaneous push/pop at full before clear keeps occupancy = 1.
